// File: rtl/m72_bus_pkg.sv
// m72_bus_pkg
// Shared types and default constants for the V30 main-CPU bus decoder and
// wait-state sequencer.
//   bus_state_t   : sequencer states (IDLE, WAIT, EXT, DONE)
//   region_cfg_t  : one decoded region (base, mask, wait states, ext flag)
//   M72_*         : the default M72 memory map (4 regions, 20-bit bus)
package m72_bus_pkg;

  localparam int MAX_REGIONS = 16;
  // Region base/mask fields are stored at this width so the struct does not
  // depend on the bus width; only bits [ADDR_W-1:1] take part in decoding.
  localparam int MAX_ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXT  = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] base;
    logic [MAX_ADDR_W-1:0] mask;
    logic [3:0]            wait_states;
    logic                  ext;
  } region_cfg_t;

  // Default M72 map. Packed arrays: element [0] is region 0, so the
  // concatenations below list region 3 first.
  localparam int M72_NUM_REGIONS = 4;
  localparam int M72_ADDR_W      = 20;

  localparam logic [3:0][19:0] M72_REGION_BASE =
    {20'hF0000, 20'h40000, 20'h20000, 20'h00000};
  localparam logic [3:0][19:0] M72_REGION_MASK =
    {20'hF0000, 20'hE0000, 20'hE0000, 20'hE0000};
  localparam logic [3:0][3:0]  M72_REGION_WAIT =
    {4'd0, 4'd1, 4'd0, 4'd0};
  localparam logic [3:0]       M72_REGION_EXT  = 4'b1011;
  localparam int unsigned      M72_TIMEOUT     = 255;

endpackage

// File: rtl/m72_region_match.sv
// m72_region_match
// Purely combinational address comparator for one decoded region.
//   addr : CPU word address [ADDR_W-1:1]
//   cfg  : region configuration (only base/mask bits [ADDR_W-1:1] are used)
//   hit  : 1 when (addr & mask) == (base & mask)
module m72_region_match
  import m72_bus_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic [ADDR_W-1:1] addr,
  input  region_cfg_t       cfg,
  output logic              hit
);

  logic [ADDR_W-1:1] mask_w;
  logic [ADDR_W-1:1] base_w;
  logic              unused_cfg;

  assign mask_w = cfg.mask[ADDR_W-1:1];
  assign base_w = cfg.base[ADDR_W-1:1];
  assign hit    = ((addr & mask_w) == (base_w & mask_w));

  // Wait/ext fields, bit 0 and bits above the bus width are not part of
  // the comparison.
  assign unused_cfg = ^cfg;

endmodule

// File: rtl/m72_bus_decode_wait.sv
// m72_bus_decode_wait
// CPU bus decoder and wait-state sequencer for the V30 main-CPU bus.
// A table of NUM_REGIONS address regions is decoded at the start of each
// memory cycle; the winning region gets a registered one-hot chip select,
// and the cycle completes either after a fixed number of wait states or
// through the ext_req/ext_ack handshake (bounded by TIMEOUT cycles).
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   addr[ADDR_W-1:1]  : CPU word address
//   m_io, rd, wr      : memory-cycle flag and read/write strobes
//   cs[NUM_REGIONS]   : registered one-hot chip selects
//   ext_req / ext_ack : external access handshake
//   ready             : CPU READY
//   unmapped, timeout : one-cycle event pulses
//   busy              : sequencer not in IDLE
//   state             : current sequencer state (debug)
//
// Handshake semantics:
//   A CPU cycle is active while strobe = m_io & (rd | wr) is high and
//   starts on its rising edge. ready is held low while the access is being
//   serviced and is high otherwise. ext_req rises at cycle start for
//   external regions and stays high until ext_ack is sampled high, the
//   timeout expires, or the CPU drops the strobe; ext_ack is ignored
//   whenever ext_req is low. Dropping the strobe mid-access aborts the
//   access without any event pulse.
module m72_bus_decode_wait
  import m72_bus_pkg::*;
#(
  parameter int                                  NUM_REGIONS = M72_NUM_REGIONS,
  parameter int                                  ADDR_W      = M72_ADDR_W,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0]  REGION_BASE = M72_REGION_BASE,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0]  REGION_MASK = M72_REGION_MASK,
  parameter logic [NUM_REGIONS-1:0][3:0]         REGION_WAIT = M72_REGION_WAIT,
  parameter logic [NUM_REGIONS-1:0]              REGION_EXT  = M72_REGION_EXT,
  parameter int unsigned                         TIMEOUT     = M72_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:1]      addr,
  input  logic                   m_io,
  input  logic                   rd,
  input  logic                   wr,
  output logic [NUM_REGIONS-1:0] cs,
  output logic                   ext_req,
  input  logic                   ext_ack,
  output logic                   ready,
  output logic                   unmapped,
  output logic                   timeout,
  output logic                   busy,
  output bus_state_t             state
);

  // One counter serves both the wait-state and the ext_ack timeout count,
  // so it must hold the larger of the two.
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (TMO_W > 4) ? TMO_W : 4;

  region_cfg_t            cfg [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit;

  logic                   strobe;
  logic                   strobe_q;
  logic                   strobe_rise;

  logic                   hit_any;
  logic [NUM_REGIONS-1:0] win_cs;
  logic [3:0]             win_wait;
  logic                   win_ext;

  logic [CNT_W-1:0]       cnt;

  // ---------------------------------------------------------------------
  // Region table and comparators
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    assign cfg[g] = '{
      base:        MAX_ADDR_W'(REGION_BASE[g]),
      mask:        MAX_ADDR_W'(REGION_MASK[g]),
      wait_states: REGION_WAIT[g],
      ext:         REGION_EXT[g]
    };

    m72_region_match #(
      .ADDR_W (ADDR_W)
    ) u_match (
      .addr (addr),
      .cfg  (cfg[g]),
      .hit  (hit[g])
    );
  end

  // Lowest-index hit wins: scan from the top down so the lowest index is
  // the last one written.
  always_comb begin
    hit_any  = 1'b0;
    win_cs   = '0;
    win_wait = '0;
    win_ext  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any   = 1'b1;
        win_cs    = '0;
        win_cs[i] = 1'b1;
        win_wait  = cfg[i].wait_states;
        win_ext   = cfg[i].ext;
      end
    end
  end

  assign strobe      = m_io & (rd | wr);
  assign strobe_rise = strobe & ~strobe_q;

  // ---------------------------------------------------------------------
  // Sequencer. Decoding happens only on the start edge; the resulting cs,
  // wait count and ext flag are held in registers for the whole cycle, so
  // later address changes have no effect.
  // Counters load N and the access completes on the edge where the count
  // would reach zero, giving N cycles of ready low.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      strobe_q <= 1'b0;
      cs       <= '0;
      ext_req  <= 1'b0;
      ready    <= 1'b1;
      unmapped <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
    end else begin
      strobe_q <= strobe;
      unmapped <= 1'b0;
      timeout  <= 1'b0;

      case (state)
        IDLE: begin
          if (strobe_rise) begin
            busy <= 1'b1;
            if (!hit_any) begin
              state    <= DONE;
              unmapped <= 1'b1;
            end else if (win_ext) begin
              state   <= EXT;
              cs      <= win_cs;
              ext_req <= 1'b1;
              ready   <= 1'b0;
              cnt     <= CNT_W'(TIMEOUT);
            end else if (win_wait == 4'd0) begin
              // Zero wait states: ready never drops.
              state <= DONE;
              cs    <= win_cs;
            end else begin
              state <= WAIT;
              cs    <= win_cs;
              ready <= 1'b0;
              cnt   <= CNT_W'(win_wait);
            end
          end
        end

        WAIT: begin
          if (!strobe) begin
            state <= IDLE;
            cs    <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt <= CNT_W'(1)) begin
            state <= DONE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        EXT: begin
          if (!strobe) begin
            state   <= IDLE;
            cs      <= '0;
            ext_req <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
          end else if (ext_ack) begin
            // An acknowledge on the final count takes precedence over the
            // timeout.
            state   <= DONE;
            ext_req <= 1'b0;
            ready   <= 1'b1;
            cnt     <= '0;
          end else if (cnt <= CNT_W'(1)) begin
            state   <= DONE;
            ext_req <= 1'b0;
            ready   <= 1'b1;
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          if (!strobe) begin
            state <= IDLE;
            cs    <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cs      <= '0;
          ext_req <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m72_bus_decode_wait.sv
// tb_m72_bus_decode_wait
// Bench for m72_bus_decode_wait: a 6-region map (the default M72 regions
// 0..3 plus two overlapping internal regions with 0 and 3 wait states),
// TIMEOUT=8. Expected per-cycle outputs are pushed to a queue when an
// access is driven and popped at each falling clock edge.
module tb_m72_bus_decode_wait;
  import m72_bus_pkg::*;

  localparam int NR = 6;
  localparam int AW = 20;
  localparam int OW = NR + 5;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:1] addr;
  logic          m_io, rd, wr, ext_ack;
  logic [NR-1:0] cs;
  logic          ext_req, ready, unmapped, timeout, busy;
  bus_state_t    state;

  always #5 clk = ~clk;

  m72_bus_decode_wait #(
    .NUM_REGIONS (NR),
    .ADDR_W      (AW),
    .REGION_BASE ({20'hC0000, 20'hC0000, 20'hF0000, 20'h40000, 20'h20000, 20'h00000}),
    .REGION_MASK ({20'hC0000, 20'hF0000, 20'hF0000, 20'hE0000, 20'hE0000, 20'hE0000}),
    .REGION_WAIT ({4'd3, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0}),
    .REGION_EXT  (6'b001011),
    .TIMEOUT     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .m_io     (m_io),
    .rd       (rd),
    .wr       (wr),
    .cs       (cs),
    .ext_req  (ext_req),
    .ext_ack  (ext_ack),
    .ready    (ready),
    .unmapped (unmapped),
    .timeout  (timeout),
    .busy     (busy),
    .state    (state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [OW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [OW-1:0] pack(input logic [NR-1:0] c, input logic e,
                                         input logic r, input logic u,
                                         input logic t, input logic b);
    return {c, e, r, u, t, b};
  endfunction

  task automatic check_sample(input string name, input int k);
    logic [OW-1:0] act;
    logic [OW-1:0] exp;
    act = {cs, ext_req, ready, unmapped, timeout, busy};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s k=%0d: scoreboard empty, got cs/req/rdy/unm/tmo/busy=%b", name, k, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        fails++;
        $display("FAIL %s k=%0d: got cs/req/rdy/unm/tmo/busy=%b expected %b", name, k, act, exp);
      end
    end
  endtask

  task automatic check_state(input string name, input bus_state_t exp);
    tests++;
    if (state !== exp) begin
      fails++;
      $display("FAIL %s: state got %0d expected %0d", name, state, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Table-driven accesses
  // ---------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] baddr;   // byte address
    logic          wr;
    logic          m_io;
    int            ack_at;  // ext_ack sampled at edge N+ack_at (0 = never)
    int            hold;    // strobe sampled high on edges N..N+hold-1
    logic [NR-1:0] cs;
    int            lat;     // cycles with ready low
    logic          ext;
    logic          unm;
    logic          tmo;
    logic          active;  // a decoded memory cycle takes place
  } vec_t;

  vec_t vecs[13];

  // Drives one access and checks samples k=1..hold+1, where sample k is the
  // output value after edge N+k-1 ("at N+k").
  task automatic run_access(input vec_t v, input string name);
    @(negedge clk);
    addr = v.baddr[AW-1:1];
    m_io = v.m_io;
    rd   = ~v.wr;
    wr   = v.wr;
    for (int k = 1; k <= v.hold + 1; k++) begin
      if (!v.active || k == v.hold + 1)
        exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      else
        exp_q.push_back(pack(v.cs, v.ext && (k <= v.lat), !(k <= v.lat),
                             v.unm && (k == 1), v.tmo && (k == v.lat + 1), 1'b1));
    end
    for (int k = 1; k <= v.hold + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_sample(name, k);
      if (k == 1) addr = ~addr;
      if (v.ack_at != 0 && k == v.ack_at) ext_ack = 1'b1;
      if (k == v.hold) begin
        rd = 1'b0;
        wr = 1'b0;
        ext_ack = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    vec_t v;
    reset = 1'b1; addr = '0; m_io = 1'b0; rd = 1'b0; wr = 1'b0; ext_ack = 1'b0;

    //            baddr      wr    m_io  ack hold cs         lat ext   unm   tmo   act
    vecs[0]  = '{20'h41000, 1'b0, 1'b1, 0, 4,  6'b000100, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{20'hF8000, 1'b0, 1'b1, 3, 6,  6'b001000, 3, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{20'h80000, 1'b0, 1'b1, 0, 3,  6'b000000, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{20'hF8000, 1'b1, 1'b1, 0, 11, 6'b001000, 8, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{20'h20000, 1'b1, 1'b1, 1, 3,  6'b000010, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{20'h00000, 1'b0, 1'b1, 2, 4,  6'b000001, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{20'h5FFFE, 1'b0, 1'b1, 0, 3,  6'b000100, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{20'h60000, 1'b1, 1'b1, 0, 2,  6'b000000, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{20'h41000, 1'b0, 1'b0, 0, 3,  6'b000000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{20'hFFFFE, 1'b1, 1'b1, 1, 3,  6'b001000, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{20'h1FFFE, 1'b0, 1'b1, 1, 3,  6'b000001, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{20'hC1230, 1'b0, 1'b1, 0, 3,  6'b010000, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{20'hD0000, 1'b1, 1'b1, 0, 5,  6'b100000, 3, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset values
    @(negedge clk);
    exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    check_sample("reset_values", 0);
    check_state("reset_state", IDLE);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_access(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while waiting for ext_ack
    @(negedge clk);
    addr = 19'(20'hF8000 >> 1); m_io = 1'b1; rd = 1'b1;
    for (int k = 1; k <= 2; k++) exp_q.push_back(pack(6'b001000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); @(negedge clk);
      check_sample("pre_reset_ext", k);
    end
    reset = 1'b1;
    #1;
    exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    check_sample("async_reset", 0);
    check_state("async_reset_state", IDLE);
    @(posedge clk); @(negedge clk);
    exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    check_sample("reset_held", 1);
    rd = 1'b0;
    reset = 1'b0;

    // Abort 2 cycles into EXT on region 0: no timeout or unmapped later
    @(negedge clk);
    addr = '0; m_io = 1'b1; rd = 1'b1;
    for (int k = 1; k <= 2; k++) exp_q.push_back(pack(6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 3; k <= 12; k++) exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      check_sample("abort_ext", k);
      if (k == 2) rd = 1'b0;
    end
    v = '{20'h20000, 1'b0, 1'b1, 1, 3, 6'b000010, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_access(v, "after_abort");

    // Abort during internal wait states (region 5, W=3)
    @(negedge clk);
    addr = 19'(20'hD0000 >> 1); m_io = 1'b1; wr = 1'b1;
    exp_q.push_back(pack(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 2; k <= 4; k++) exp_q.push_back(pack('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      check_sample("abort_wait", k);
      if (k == 1) wr = 1'b0;
    end
    check_state("abort_wait_state", IDLE);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover: %0d expected samples never compared, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
